// File: rtl/shift_reg_sipo_deser.sv
// shift_reg_sipo_deser: MSB-first serial-to-parallel deserializer with a
// one-deep valid/ready output stage and sticky overrun / parity flags.
// Optional feature macro: SIPO_PARITY_EN (adds one even-parity bit per frame
// and makes parity_err functional; otherwise parity_err is constant 0).
module shift_reg_sipo_deser #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_e;

`ifdef SIPO_PARITY_EN
  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               offer_s;
  logic [WIDTH-1:0]   offer_word_s;
`ifdef SIPO_PARITY_EN
  logic               perr_q, perr_d;
`endif

  // Next-state: bit collection FSM, output stage and sticky flags; clr overrides all.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;
    offer_s      = 1'b0;
    offer_word_s = '0;
`ifdef SIPO_PARITY_EN
    perr_d       = perr_q;
`endif

    case (state_q)
      ST_COLLECT: begin
        if (bit_valid) begin
          shreg_d = {shreg_q[WIDTH-2:0], bit_in};
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
`ifdef SIPO_PARITY_EN
            state_d = ST_PARITY;
`else
            offer_s      = 1'b1;
            offer_word_s = {shreg_q[WIDTH-2:0], bit_in};
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          shreg_d = shreg_q;
        end
      end
`ifdef SIPO_PARITY_EN
      ST_PARITY: begin
        if (bit_valid) begin
          state_d = ST_COLLECT;
          if (even_parity(shreg_q) == bit_in) begin
            offer_s      = 1'b1;
            offer_word_s = shreg_q;
          end else begin
            perr_d = 1'b1;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    // Output stage: a word is taken when the slot is empty or being drained.
    if (offer_s) begin
      if (!valid_q || word_ready) begin
        word_d  = offer_word_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (clr) begin
      state_d = ST_COLLECT;
      shreg_d = '0;
      cnt_d   = '0;
      word_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      state_d = state_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // Sticky parity error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_shift_reg_sipo_deser.sv
// Scoreboard bench for shift_reg_sipo_deser (WIDTH=4). Works in both builds;
// the parity scenarios are compiled only with SIPO_PARITY_EN.
module tb_shift_reg_sipo_deser;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             bit_in;
  logic             bit_valid;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
  logic             parity_err;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_reg_sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .bit_count  (bit_count),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer (valid & ready) pops and compares the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got word %0h with empty scoreboard", word_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (word_out !== e) begin
          bad++;
          $display("FAIL sb_word: got %0h expected %0h", word_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Sends a full frame; optionally raises word_ready just before the last frame bit.
  task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
      if (i == 0 && rdy_last) word_ready = 1'b1;
`endif
      send_bit(w[i]);
    end
`ifdef SIPO_PARITY_EN
    if (rdy_last) word_ready = 1'b1;
    send_bit(^w);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst_n      = 1'b0;
    clr        = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_word_out", word_out, 0);
    check("rst_valid", word_valid, 0);
    check("rst_count", bit_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);

    // 1: single word 1101, valid for exactly one cycle
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0);
    check("t1_valid", word_valid, 1);
    check("t1_word", word_out, 4'b1101);
    tick();
    check("t1_valid_drop", word_valid, 0);

    // 2: overrun while 1101 is held
    word_ready = 1'b0;
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0);
    check("t2_valid", word_valid, 1);
    send_word(4'b0110, 1'b0);
    check("t2_overrun", overrun, 1);
    check("t2_word_held", word_out, 4'b1101);
    check("t2_valid_held", word_valid, 1);
    word_ready = 1'b1;
    tick();
    check("t2_valid_clear", word_valid, 0);
    check("t2_overrun_sticky", overrun, 1);

    // clr returns flags to zero
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overrun", overrun, 0);

    // 3: offer and transfer on the same edge
    word_ready = 1'b0;
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 1'b0);
    check("t3_valid_first", word_valid, 1);
    exp_q.push_back(4'b0110);
    send_word(4'b0110, 1'b1);
    check("t3_valid_kept", word_valid, 1);
    check("t3_word_new", word_out, 4'b0110);
    check("t3_no_overrun", overrun, 0);
    tick();
    check("t3_valid_drop", word_valid, 0);

    // 4: async reset mid-word, then a gapped word
    send_bit(1'b1);
    send_bit(1'b0);
    check("t4_count_mid", bit_count, 2);
    rst_n = 1'b0;
    #2;
    check("t4_count_rst", bit_count, 0);
    rst_n = 1'b1;
    tick();
    w = 4'b0110;
    exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == WIDTH - 1) check("t4_count_first", bit_count, 1);
      if (i != 0) tick();
    end
`ifdef SIPO_PARITY_EN
    tick();
    send_bit(^w);
`endif
    check("t4_valid", word_valid, 1);
    check("t4_word", word_out, 4'b0110);
    tick();

    // 5: continuous back-to-back words with ready held high
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0101);
    send_word(4'b1010, 1'b0);
    send_word(4'b0101, 1'b0);
    check("t5_word", word_out, 4'b0101);
    check("t5_no_overrun", overrun, 0);
    tick();

    // 6: counter boundary
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t6_count3", bit_count, 3);
    exp_q.push_back(4'b1110);
    send_bit(1'b0);
    check("t6_count_wrap", bit_count, 0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b1);
`endif
    check("t6_word", word_out, 4'b1110);
    tick();

`ifdef SIPO_PARITY_EN
    // 7: good parity accepted
    exp_q.push_back(4'b1101);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("p_count_in_parity", bit_count, 0);
    send_bit(1'b1);
    check("p_good_valid", word_valid, 1);
    check("p_good_err", parity_err, 0);
    tick();
    // 8: bad parity discarded
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0);
    check("p_bad_valid", word_valid, 0);
    check("p_bad_err", parity_err, 1);
    // 9: clr resets everything
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("p_clr_err", parity_err, 0);
    check("p_clr_word", word_out, 0);
    check("p_clr_valid", word_valid, 0);
    check("p_clr_count", bit_count, 0);
`endif

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
